// File: rtl/operand_stage_if.sv
// Decode-to-execute operand bus: decoded instruction in, register-file read port,
// forwarding sources, and the registered execute payload out.
interface operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int EXOP_W  = 8,
  parameter int NFWD    = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [EXOP_W-1:0]         in_exop;
  logic [RADDR_W-1:0]        in_addr_a;
  logic [RADDR_W-1:0]        in_addr_b;
  logic [1:0]                in_sel_a;
  logic [1:0]                in_sel_b;
  logic [DATA_W-1:0]         in_imm;
  logic [DATA_W-1:0]         in_offset;
  logic [RADDR_W-1:0]        in_dest;

  logic [RADDR_W-1:0]        rf_addr_a;
  logic [RADDR_W-1:0]        rf_addr_b;
  logic [DATA_W-1:0]         rf_data_a;
  logic [DATA_W-1:0]         rf_data_b;

  logic [NFWD-1:0]           fwd_we;
  logic [NFWD-1:0]           fwd_rdy;
  logic [NFWD*RADDR_W-1:0]   fwd_dest;
  logic [NFWD*DATA_W-1:0]    fwd_data;

  logic                      flush;

  logic                      out_valid;
  logic                      out_ready;
  logic [EXOP_W-1:0]         out_exop;
  logic [DATA_W-1:0]         out_src_a;
  logic [DATA_W-1:0]         out_src_b;
  logic [DATA_W-1:0]         out_offset;
  logic [RADDR_W-1:0]        out_dest;

  logic [15:0]               stall_cnt;

  modport master (
    output in_valid, in_exop, in_addr_a, in_addr_b, in_sel_a, in_sel_b,
           in_imm, in_offset, in_dest,
    output rf_data_a, rf_data_b,
    output fwd_we, fwd_rdy, fwd_dest, fwd_data,
    output flush, out_ready,
    input  in_ready, rf_addr_a, rf_addr_b,
    input  out_valid, out_exop, out_src_a, out_src_b, out_offset, out_dest,
    input  stall_cnt
  );

  modport slave (
    input  in_valid, in_exop, in_addr_a, in_addr_b, in_sel_a, in_sel_b,
           in_imm, in_offset, in_dest,
    input  rf_data_a, rf_data_b,
    input  fwd_we, fwd_rdy, fwd_dest, fwd_data,
    input  flush, out_ready,
    output in_ready, rf_addr_a, rf_addr_b,
    output out_valid, out_exop, out_src_a, out_src_b, out_offset, out_dest,
    output stall_cnt
  );
endinterface

// File: rtl/operand_stage.sv
// Operand-fetch stage: resolves both operands (zero / immediate / forwarded / register file),
// stalls on not-yet-ready producers and registers the execute payload behind a valid/ready handshake.
module operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int EXOP_W  = 8,
  parameter int NFWD    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_stage_if.slave bus
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              hazard;
  logic              fire;

  // Returns {hazard, value}. Walking from the oldest source down lets the youngest match win.
  function automatic logic [DATA_W:0] resolve(
    input logic [1:0]              sel,
    input logic [RADDR_W-1:0]      addr,
    input logic [DATA_W-1:0]       rf_data,
    input logic [DATA_W-1:0]       imm,
    input logic [NFWD-1:0]         we,
    input logic [NFWD-1:0]         rdy,
    input logic [NFWD*RADDR_W-1:0] dest,
    input logic [NFWD*DATA_W-1:0]  data
  );
    logic [DATA_W:0] r;
    r = '0;
    if (sel == 2'b10) begin
      r = {1'b0, imm};
    end else if (sel == 2'b01 && addr != '0) begin
      r = {1'b0, rf_data};
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (we[i] && dest[i*RADDR_W +: RADDR_W] == addr)
          r = {~rdy[i], {DATA_W{rdy[i]}} & data[i*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign {hazard_a, src_a} = resolve(bus.in_sel_a, bus.in_addr_a, bus.rf_data_a, bus.in_imm,
                                     bus.fwd_we, bus.fwd_rdy, bus.fwd_dest, bus.fwd_data);
  assign {hazard_b, src_b} = resolve(bus.in_sel_b, bus.in_addr_b, bus.rf_data_b, bus.in_imm,
                                     bus.fwd_we, bus.fwd_rdy, bus.fwd_dest, bus.fwd_data);

  assign bus.rf_addr_a = bus.in_addr_a;
  assign bus.rf_addr_b = bus.in_addr_b;

  assign hazard       = bus.in_valid & (hazard_a | hazard_b);
  // Gating with rst_n keeps an instruction offered during reset from being reported as taken.
  assign bus.in_ready = rst_n & ~hazard & ~bus.flush & (~bus.out_valid | bus.out_ready);
  assign fire         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_exop   <= '0;
      bus.out_src_a  <= '0;
      bus.out_src_b  <= '0;
      bus.out_offset <= '0;
      bus.out_dest   <= '0;
      bus.stall_cnt  <= '0;
    end else begin
      if (bus.flush || (!fire && bus.out_ready)) begin
        bus.out_valid  <= 1'b0;
        bus.out_exop   <= '0;
        bus.out_src_a  <= '0;
        bus.out_src_b  <= '0;
        bus.out_offset <= '0;
        bus.out_dest   <= '0;
      end else if (fire) begin
        bus.out_valid  <= 1'b1;
        bus.out_exop   <= bus.in_exop;
        bus.out_src_a  <= src_a;
        bus.out_src_b  <= src_b;
        bus.out_offset <= bus.in_offset;
        bus.out_dest   <= bus.in_dest;
      end

      if (hazard && !bus.flush && bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 The block SHALL have parameter RADDR_W, default 5, register address width.
REQ-003 The block SHALL have parameter EXOP_W, default 8, execute opcode width.
REQ-004 The block SHALL have parameter NFWD, default 2, number of forwarding sources; index 0 has the highest priority (youngest).
REQ-005 Ports, in this order: clk in 1, rising-edge clock; rst_n in 1, reset. Reset is synchronous and active-low.
REQ-006 Ports: in_valid in 1, decoded instruction present; in_ready out 1, instruction accepted this cycle.
REQ-007 Ports: in_exop in EXOP_W; in_addr_a, in_addr_b in RADDR_W; in_sel_a, in_sel_b in 2, operand source, 00 zero, 01 register, 10 immediate.
REQ-008 Ports: in_imm in DATA_W; in_offset in DATA_W; in_dest in RADDR_W.
REQ-009 Ports: rf_addr_a, rf_addr_b out RADDR_W, register-file read addresses; rf_data_a, rf_data_b in DATA_W, register-file read data.
REQ-010 Ports: fwd_we in NFWD, source will write a register; fwd_rdy in NFWD, source value is available; fwd_dest in NFWD*RADDR_W; fwd_data in NFWD*DATA_W.
REQ-011 Ports: flush in 1, discard the held output.
REQ-012 Ports: out_valid out 1; out_ready in 1; out_exop out EXOP_W; out_src_a, out_src_b out DATA_W; out_offset out DATA_W; out_dest out RADDR_W.
REQ-013 Ports: stall_cnt out 16, count of hazard cycles.

Function
REQ-014 rf_addr_a SHALL equal in_addr_a combinationally, and rf_addr_b SHALL equal in_addr_b combinationally.
REQ-015 Operand resolution, per operand X: sel 00 or 11 -> 0; sel 10 -> in_imm; sel 01 with address 0 -> 0.
REQ-016 Operand resolution, sel 01 with a non-zero address: select the lowest index i with fwd_we[i]=1 and fwd_dest[i] equal to the address; if fwd_rdy[i]=1, use fwd_data[i]; otherwise raise hazard_X.
REQ-017 Operand resolution, sel 01 with a non-zero address and no matching source: use rf_data_X.
REQ-018 Sources with fwd_we=0 SHALL never match, and lower-priority matches SHALL be ignored.
REQ-019 hazard = in_valid & (hazard_a | hazard_b).
REQ-020 in_ready = !hazard & !flush & (!out_valid | out_ready), combinational.
REQ-021 fire = in_valid & in_ready.
REQ-022 On fire, the output register SHALL load exop, the resolved operands, offset and dest, and set out_valid=1, with 1-cycle latency.
REQ-023 Without fire: if out_ready=1, out_valid SHALL go to 0 (a bubble); otherwise the held output SHALL remain stable.
REQ-024 flush=1 SHALL clear out_valid on the next edge and block acceptance that cycle; flush takes priority over fire.
REQ-025 Output payload fields SHALL be cleared to 0 whenever out_valid is cleared.
REQ-026 stall_cnt SHALL increment on each cycle with hazard=1 and !flush, and SHALL saturate at 0xFFFF.
REQ-027 Simultaneous out_ready=1 and fire SHALL give back-to-back transfer with no bubble.

Reset
REQ-028 While rst_n=0 at the clock edge: out_valid=0, out_exop=0, out_src_a=0, out_src_b=0, out_offset=0, out_dest=0, stall_cnt=0.
REQ-029 in_ready SHALL be 0 during reset, and an instruction presented in a reset cycle SHALL be dropped.
REQ-030 Reset asserted mid-stall SHALL discard the held output and clear stall_cnt.

Verification
REQ-031 Forwarding priority: sel_a=01 with addr 3, fwd0 and fwd1 both writing r3 and ready, data 0xAAAA and 0x5555 -> out_src_a=0xAAAA one cycle later.
REQ-032 Load-use stall: fwd0 writes r4 with fwd_rdy=0, sel_b=01 with addr 4 -> in_ready=0 and stall_cnt increments each cycle. Raising fwd_rdy with data 0x1234 -> accepted, out_src_b=0x1234.
REQ-033 r0 handling: addr_a=0 with fwd0 writing r0 with data 0xFFFF -> out_src_a=0 and no stall.
REQ-034 Backpressure: out_ready=0 for 3 cycles -> outputs held and in_ready=0. With out_ready=1 and a continuous valid input -> one transfer per cycle.
REQ-035 Flush with out_valid=1 and a simultaneous valid input -> next cycle out_valid=0 and the input is not consumed.
REQ-036 Saturation: hold a hazard for 70000 cycles -> stall_cnt=0xFFFF. Then apply rst_n=0 for one cycle -> stall_cnt=0 and out_valid=0.
